// File: rtl/tape_ear_conditioner.sv
// Tape EAR input conditioner: DC midpoint tracking, hysteresis slicing, debounce
// and tape-activity detection feeding a clean ear bit to the computer core.
module tape_ear_conditioner #(
    parameter int ADC_W        = 12,
    parameter int HYST         = 32,
    parameter int DEBOUNCE     = 4,
    parameter int ACT_EDGES    = 8,
    parameter int IDLE_TIMEOUT = 50000
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             adc_valid,
    input  logic [ADC_W-1:0] adc_data,
    output logic             ear,
    output logic             active,
    output logic             edge_stb,
    output logic [ADC_W-1:0] mid_level
);

    localparam int ACC_W = ADC_W + 6;

    typedef enum logic [1:0] {IDLE, ARMING, ACTIVE} state_t;

    state_t                  state, state_next;
    logic                    s1_valid;
    logic [ADC_W-1:0]        s1_data;
    logic [ACC_W-1:0]        acc, acc_next;
    logic                    raw, raw_next;
    logic                    level, level_next;
    logic [3:0]              db_cnt, db_cnt_next;
    logic [7:0]              edge_cnt, edge_cnt_next;
    logic [15:0]             to_cnt, to_cnt_next;
    logic                    edge_ev, timeout;
    logic [ADC_W:0]          thr_hi_sum;
    logic [ADC_W-1:0]        thr_hi, thr_lo;
    logic signed [ACC_W:0]   diff, step, acc_sum;

    assign mid_level  = acc[ACC_W-1:6];
    assign thr_hi_sum = {1'b0, mid_level} + (ADC_W+1)'(HYST);
    assign thr_hi     = thr_hi_sum[ADC_W] ? '1 : thr_hi_sum[ADC_W-1:0];
    assign thr_lo     = (mid_level < ADC_W'(HYST)) ? '0 : mid_level - ADC_W'(HYST);

    // Leaky integrator: move 1/64 of the way from the midpoint toward the sample.
    assign diff    = $signed({1'b0, s1_data, 6'b0}) - $signed({1'b0, acc});
    assign step    = diff >>> 6;
    assign acc_sum = $signed({1'b0, acc}) + step;

    always_comb begin
        acc_next      = acc;
        raw_next      = raw;
        level_next    = level;
        db_cnt_next   = db_cnt;
        edge_ev       = 1'b0;
        to_cnt_next   = to_cnt;
        state_next    = state;
        edge_cnt_next = edge_cnt;

        if (s1_valid) begin
            acc_next = acc_sum[ACC_W-1:0];
            if (s1_data > thr_hi)
                raw_next = 1'b1;
            else if (s1_data < thr_lo)
                raw_next = 1'b0;

            if (raw_next != level) begin
                if (db_cnt == 4'(DEBOUNCE - 1)) begin
                    level_next  = ~level;
                    db_cnt_next = '0;
                    edge_ev     = 1'b1;
                end else begin
                    db_cnt_next = db_cnt + 4'd1;
                end
            end else begin
                db_cnt_next = '0;
            end

            if (to_cnt != 16'(IDLE_TIMEOUT))
                to_cnt_next = to_cnt + 16'd1;
        end

        if (edge_ev)
            to_cnt_next = '0;
        // An edge clears the counter, so it always beats a coincident timeout.
        timeout = s1_valid && (to_cnt_next == 16'(IDLE_TIMEOUT));

        case (state)
            IDLE: begin
                to_cnt_next = '0;
                if (edge_ev) begin
                    edge_cnt_next = 8'd1;
                    state_next    = (ACT_EDGES == 1) ? ACTIVE : ARMING;
                end
            end
            ARMING: begin
                if (edge_ev) begin
                    edge_cnt_next = edge_cnt + 8'd1;
                    if (edge_cnt_next == 8'(ACT_EDGES))
                        state_next = ACTIVE;
                end else if (timeout) begin
                    state_next    = IDLE;
                    edge_cnt_next = '0;
                end
            end
            ACTIVE: begin
                if (timeout) begin
                    state_next    = IDLE;
                    edge_cnt_next = '0;
                end
            end
            default: begin
                state_next    = IDLE;
                edge_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            acc      <= {1'b1, {(ACC_W-1){1'b0}}};
            raw      <= 1'b0;
            level    <= 1'b0;
            db_cnt   <= '0;
            edge_cnt <= '0;
            to_cnt   <= '0;
            state    <= IDLE;
            ear      <= 1'b0;
            active   <= 1'b0;
            edge_stb <= 1'b0;
        end else begin
            s1_valid <= adc_valid;
            s1_data  <= adc_data;
            acc      <= acc_next;
            raw      <= raw_next;
            level    <= level_next;
            db_cnt   <= db_cnt_next;
            edge_cnt <= edge_cnt_next;
            to_cnt   <= to_cnt_next;
            state    <= state_next;
            ear      <= level_next & (state_next == ACTIVE);
            active   <= (state_next == ACTIVE);
            edge_stb <= edge_ev;
        end
    end

endmodule

// File: tb/tb_tape_ear_conditioner.sv
// Directed bench for tape_ear_conditioner; a second instance with a short idle
// timeout makes every square-wave edge coincide with a timeout.
module tb_tape_ear_conditioner;

    logic        clock;
    logic        reset_n;
    logic        adc_valid;
    logic [11:0] adc_data;
    logic        ear, active, edge_stb;
    logic [11:0] mid_level;
    logic        s_ear, s_active, s_edge_stb;
    logic [11:0] s_mid_level;

    int n_checks = 0;
    int n_fail   = 0;

    tape_ear_conditioner dut (
        .clock(clock), .reset_n(reset_n), .adc_valid(adc_valid), .adc_data(adc_data),
        .ear(ear), .active(active), .edge_stb(edge_stb), .mid_level(mid_level)
    );

    tape_ear_conditioner #(.IDLE_TIMEOUT(8)) u_short (
        .clock(clock), .reset_n(reset_n), .adc_valid(adc_valid), .adc_data(adc_data),
        .ear(s_ear), .active(s_active), .edge_stb(s_edge_stb), .mid_level(s_mid_level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [11:0] d);
        @(negedge clock);
        adc_valid = 1'b1;
        adc_data  = d;
    endtask

    task automatic send_n(input int n, input logic [11:0] d);
        for (int k = 0; k < n; k++) send(d);
    endtask

    // Two idle cycles: the last sample reaches the outputs.
    task automatic drain();
        @(negedge clock);
        adc_valid = 1'b0;
        @(negedge clock);
    endtask

    // 8 x 3000 then 8 x 1000, 8 periods. Observation at step i shows sample i-2.
    task automatic run_wave();
        int j, e;
        logic exp_edge, exp_act, exp_ear;
        for (int i = 0; i < 130; i++) begin
            @(negedge clock);
            if (i >= 2) begin
                j        = i - 2;
                e        = (j >= 3) ? ((j - 3) / 8 + 1) : 0;
                exp_edge = (j % 8 == 3);
                exp_act  = (j >= 59);
                exp_ear  = exp_act && (e % 2 == 1);
                check("wave_edge_stb", edge_stb, exp_edge);
                check("wave_active", active, exp_act);
                check("wave_ear", ear, exp_ear);
                check("wave_short_active", s_active, exp_act);
            end
            if (i == 2) check("wave_mid_1", mid_level, 2062);
            if (i == 3) check("wave_mid_2", mid_level, 2077);
            if (i < 128) begin
                adc_valid = 1'b1;
                adc_data  = ((i / 8) % 2 == 0) ? 12'd3000 : 12'd1000;
            end else begin
                adc_valid = 1'b0;
            end
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        adc_valid = 1'b0;
        adc_data  = '0;
        #12;
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_ear", ear, 0);
        check("rst_active", active, 0);
        check("rst_edge_stb", edge_stb, 0);
        check("rst_mid", mid_level, 2048);

        // Hysteresis: alternating 2060/2036, then short runs on each side of the midpoint.
        for (int i = 0; i < 34; i++) begin
            @(negedge clock);
            if (i >= 2) check("hyst_edge_stb", edge_stb, 0);
            if (i == 2) check("hyst_mid_1", mid_level, 2048);
            if (i == 3) check("hyst_mid_2", mid_level, 2047);
            if (i < 32) begin
                adc_valid = 1'b1;
                if (i < 16)      adc_data = (i % 2 == 0) ? 12'd2060 : 12'd2036;
                else if (i < 24) adc_data = 12'd2060;
                else             adc_data = 12'd2036;
            end else begin
                adc_valid = 1'b0;
            end
        end
        check("hyst_active", active, 0);

        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;

        run_wave();

        // Glitch: three high samples inside a steady low stream.
        for (int i = 0; i < 35; i++) begin
            @(negedge clock);
            check("glitch_edge_stb", edge_stb, 0);
            check("glitch_active", active, 1);
            check("glitch_ear", ear, 0);
            if (i < 33) begin
                adc_valid = 1'b1;
                adc_data  = (i >= 20 && i < 23) ? 12'd3000 : 12'd1000;
            end else begin
                adc_valid = 1'b0;
            end
        end

        send_n(8, 12'd3000);
        drain();
        check("pre_rst_ear", ear, 1);
        check("pre_rst_active", active, 1);

        // Asynchronous reset between clock edges while streaming.
        adc_valid = 1'b1;
        adc_data  = 12'd3000;
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_ear", ear, 0);
        check("async_rst_active", active, 0);
        check("async_rst_edge_stb", edge_stb, 0);
        check("async_rst_mid", mid_level, 2048);
        @(negedge clock);
        @(negedge clock);
        adc_valid = 1'b0;
        reset_n   = 1'b1;

        run_wave();

        // Last edge was wave sample 123; the wave delivered 4 more samples.
        send_n(3, 12'd1000);
        drain();
        check("short_before_timeout", s_active, 1);
        send(12'd1000);
        drain();
        check("short_at_timeout", s_active, 0);
        check("short_ear_at_timeout", s_ear, 0);

        send_n(49991, 12'd1000);
        drain();
        check("before_timeout_active", active, 1);
        send(12'd1000);
        drain();
        check("timeout_active", active, 0);
        check("timeout_ear", ear, 0);
        check("timeout_edge_stb", edge_stb, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
